stopwatch_ctrl: RTL

Control stage directly upstream of secondcounter. It sits between the OneHertz tick and the seconds counter, and between the counter and the bin_2_7 decoders.
- Debounces two push-buttons: start/stop and lap/reset.
- Runs a stopwatch state machine.
- Gates the 1 Hz tick into the counter enable and issues a counter clear.
- Freezes the displayed tens/units digits on a lap.

---
 rtl/stopwatch_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces start/stop and lap/reset buttons, runs the stopwatch FSM,
// gates the 1 Hz tick into the counter enable and freezes the displayed digits on a lap.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       ss_btn,
  input  logic       lap_btn,
  input  logic [2:0] ts_in,
  input  logic [3:0] ss_in,
  output logic       en_out,
  output logic       clr_out,
  output logic [2:0] ts_out,
  output logic [3:0] ss_out,
  output logic       run_led,
  output logic       lap_led
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] LAP    = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;
  logic [1:0] btn, press;
  logic [1:0] state_q, state_d;
  logic [2:0] hold_ts_q;
  logic [3:0] hold_ss_q;
  logic       clr_q, ss_p, lap_p, active;
  assign btn = {lap_btn, ss_btn};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1_q, s2_q, db_q, db_prev_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= btn[b];
        s2_q      <= s1_q;
        db_prev_q <= db_q;
        if (s2_q == db_q) cnt_q <= '0;
        else if (cnt_q == CW'(DB_CYCLES)) begin
          db_q  <= s2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign press[b] = db_q & ~db_prev_q;
  end
  // start/stop has priority: a lap press in the same cycle is dropped
  assign ss_p   = press[0];
  assign lap_p  = press[1] & ~press[0];
  assign active = state_q == RUN || state_q == LAP;
  always_comb begin
    state_d = state_q;
    if (ss_p) state_d = active ? PAUSED : RUN;
    else if (lap_p) state_d = state_q == RUN ? LAP : state_q == LAP ? RUN : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_ts_q <= '0;
      hold_ss_q <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= lap_p && state_q == PAUSED;
      if (lap_p && state_q == RUN) begin
        hold_ts_q <= ts_in;
        hold_ss_q <= ss_in;
      end
    end
  end
  assign en_out  = tick_in & active;
  assign clr_out = clr_q;
  assign ts_out  = state_q == LAP ? hold_ts_q : ts_in;
  assign ss_out  = state_q == LAP ? hold_ss_q : ss_in;
  assign run_led = active;
  assign lap_led = state_q == LAP;
endmodule
